video_color_adjust: RTL and testbench

// - Consumer of the contrast/brightness/saturation settings produced by the button-driven parameter controller.
// - Applies those settings to a YUV 4:4:4 pixel stream, in place between the YUV converter and the scaler.
// - Shadow-latches the settings once per frame, at vsync, so a frame never tears mid-picture.
// - 3-stage pipeline. One pixel per clk when in_valid. No backpressure.

---
 rtl/video_color_adjust.sv | 160 ++++++++++++++++
 tb/tb_video_color_adjust.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/video_color_adjust.sv
// rtl/video_color_adjust.sv - YUV 4:4:4 contrast/brightness/saturation adjust, 3-stage pipeline, vsync-latched shadows
// Optional luma clip statistics: define COLOR_ADJUST_STATS_EN to build clip_count.
module video_color_adjust #(
  parameter int Y_SHIFT     = 2,
  parameter int SAT_SHIFT   = 7,
  parameter int BRIGHT_BIAS = 4000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [13:0] contrast_gain,
  input  logic signed [13:0] brightness_offset,
  input  logic signed [13:0] saturation_gain,
  input  logic               in_valid,
  input  logic [7:0]         in_y,
  input  logic [7:0]         in_u,
  input  logic [7:0]         in_v,
  input  logic               in_hsync,
  input  logic               in_vsync,
  input  logic               in_de,
  output logic               out_valid,
  output logic [7:0]         out_y,
  output logic [7:0]         out_u,
  output logic [7:0]         out_v,
  output logic               out_hsync,
  output logic               out_vsync,
  output logic               out_de,
  output logic               param_pending
`ifdef COLOR_ADJUST_STATS_EN
  ,
  output logic [15:0]        clip_count
`endif
);

  typedef enum logic {ST_IDLE, ST_PENDING} state_t;

  localparam logic [24:0] LP_BIAS = 25'(BRIGHT_BIAS);

  state_t             r_state;
  logic               r_vsync_d;
  logic signed [13:0] r_sh_con, r_sh_bri, r_sh_sat;

  logic               r1_valid, r1_hs, r1_vs, r1_de;
  logic [7:0]         r1_y;
  logic signed [8:0]  r1_u, r1_v;

  logic               r2_valid, r2_hs, r2_vs, r2_de;
  logic signed [22:0] r2_yp, r2_up, r2_vp;

  logic               w_vs_rise;
  logic signed [22:0] w_y_ext, w_u_ext, w_v_ext, w_con_ext, w_sat_ext;
  logic signed [24:0] w_ysum, w_ysh, w_usum, w_vsum;
  logic signed [22:0] w_ush, w_vsh;

  assign w_vs_rise = in_vsync & ~r_vsync_d;

  // Everything is widened to 23 bits up front so the products are exact.
  assign w_y_ext   = {15'd0, r1_y};
  assign w_u_ext   = {{14{r1_u[8]}}, r1_u};
  assign w_v_ext   = {{14{r1_v[8]}}, r1_v};
  assign w_con_ext = {{9{r_sh_con[13]}}, r_sh_con};
  assign w_sat_ext = {{9{r_sh_sat[13]}}, r_sh_sat};

  assign w_ysum = {{2{r2_yp[22]}}, r2_yp} + {{11{r_sh_bri[13]}}, r_sh_bri} - LP_BIAS;
  assign w_ysh  = w_ysum >>> Y_SHIFT;
  assign w_ush  = r2_up >>> SAT_SHIFT;
  assign w_vsh  = r2_vp >>> SAT_SHIFT;
  assign w_usum = {{2{w_ush[22]}}, w_ush} + 25'd128;
  assign w_vsum = {{2{w_vsh[22]}}, w_vsh} + 25'd128;

  function automatic logic [7:0] clamp8(input logic [24:0] x);
    if (x[24])                 return 8'd0;
    else if (x[23:8] != 16'd0) return 8'd255;
    else                       return x[7:0];
  endfunction

  // Shadow settings: only the datapath's view changes, and only on a vsync edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_vsync_d     <= 1'b0;
      r_sh_con      <= 14'sd4;
      r_sh_bri      <= 14'(BRIGHT_BIAS);
      r_sh_sat      <= 14'sd128;
      param_pending <= 1'b0;
    end else begin
      r_vsync_d <= in_vsync;
      case (r_state)
        ST_IDLE: begin
          if (contrast_gain != r_sh_con || brightness_offset != r_sh_bri ||
              saturation_gain != r_sh_sat) begin
            r_state       <= ST_PENDING;
            param_pending <= 1'b1;
          end
        end
        ST_PENDING: begin
          if (w_vs_rise) begin
            r_sh_con      <= contrast_gain;
            r_sh_bri      <= brightness_offset;
            r_sh_sat      <= saturation_gain;
            r_state       <= ST_IDLE;
            param_pending <= 1'b0;
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          param_pending <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r1_valid <= 1'b0; r1_hs <= 1'b0; r1_vs <= 1'b0; r1_de <= 1'b0;
      r1_y <= 8'd0; r1_u <= 9'sd0; r1_v <= 9'sd0;
      r2_valid <= 1'b0; r2_hs <= 1'b0; r2_vs <= 1'b0; r2_de <= 1'b0;
      r2_yp <= 23'sd0; r2_up <= 23'sd0; r2_vp <= 23'sd0;
      out_valid <= 1'b0; out_hsync <= 1'b0; out_vsync <= 1'b0; out_de <= 1'b0;
      out_y <= 8'd0; out_u <= 8'd0; out_v <= 8'd0;
    end else begin
      r1_valid <= in_valid; r1_hs <= in_hsync; r1_vs <= in_vsync; r1_de <= in_de;
      r1_y <= in_y;
      r1_u <= $signed({1'b0, in_u}) - 9'sd128;
      r1_v <= $signed({1'b0, in_v}) - 9'sd128;

      r2_valid <= r1_valid; r2_hs <= r1_hs; r2_vs <= r1_vs; r2_de <= r1_de;
      r2_yp <= w_y_ext * w_con_ext;
      r2_up <= w_u_ext * w_sat_ext;
      r2_vp <= w_v_ext * w_sat_ext;

      out_valid <= r2_valid; out_hsync <= r2_hs; out_vsync <= r2_vs; out_de <= r2_de;
      out_y <= clamp8(w_ysum >>> Y_SHIFT);
      out_u <= clamp8(w_usum);
      out_v <= clamp8(w_vsum);
    end
  end

`ifdef COLOR_ADJUST_STATS_EN
  logic        w_clip;
  logic [15:0] r_clip_cnt;

  assign w_clip = r2_valid & (w_ysh[24] | (w_ysh[23:8] != 16'd0));

  // The pixel finishing S3 on the vsync edge opens the new frame's count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clip_cnt <= 16'd0;
      clip_count <= 16'd0;
    end else if (w_vs_rise) begin
      clip_count <= r_clip_cnt;
      r_clip_cnt <= {15'd0, w_clip};
    end else if (w_clip && r_clip_cnt != 16'hFFFF) begin
      r_clip_cnt <= r_clip_cnt + 16'd1;
    end
  end
`else
  // Statistics are not built: no counter and no clip_count port.
`endif

endmodule

// File: tb/tb_video_color_adjust.sv
// tb/tb_video_color_adjust.sv - directed self-checking bench for video_color_adjust
module tb_video_color_adjust;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [13:0] con = 14'sd4, bri = 14'sd4000, sat = 14'sd128;
  logic               in_valid = 1'b0, in_hsync = 1'b0, in_vsync = 1'b0, in_de = 1'b0;
  logic [7:0]         in_y = 8'd0, in_u = 8'd128, in_v = 8'd128;
  logic               out_valid, out_hsync, out_vsync, out_de, param_pending;
  logic [7:0]         out_y, out_u, out_v;
`ifdef COLOR_ADJUST_STATS_EN
  logic [15:0]        clip_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  video_color_adjust dut (
    .clk(clk), .rst(rst),
    .contrast_gain(con), .brightness_offset(bri), .saturation_gain(sat),
    .in_valid(in_valid), .in_y(in_y), .in_u(in_u), .in_v(in_v),
    .in_hsync(in_hsync), .in_vsync(in_vsync), .in_de(in_de),
    .out_valid(out_valid), .out_y(out_y), .out_u(out_u), .out_v(out_v),
    .out_hsync(out_hsync), .out_vsync(out_vsync), .out_de(out_de),
    .param_pending(param_pending)
`ifdef COLOR_ADJUST_STATS_EN
    , .clip_count(clip_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive one valid pixel, then wait until it reaches the outputs.
  task automatic px(input logic [7:0] y, input logic [7:0] u, input logic [7:0] v);
    in_valid = 1'b1; in_y = y; in_u = u; in_v = v;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
  endtask

  task automatic vsync_pulse;
    in_vsync = 1'b1;
    tick;
    in_vsync = 1'b0;
    tick;
  endtask

  initial begin
    tick;
    tick;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_y", 32'(out_y), 32'd0);
    chk("rst_pending", 32'(param_pending), 32'd0);
`ifdef COLOR_ADJUST_STATS_EN
    chk("rst_clip", 32'(clip_count), 32'd0);
`endif
    rst = 1'b0;
    tick;

    // Defaults pass through, syncs delayed 3 clk with the data.
    in_hsync = 1'b1; in_de = 1'b1;
    in_valid = 1'b1; in_y = 8'd100; in_u = 8'd200; in_v = 8'd50;
    tick;
    in_valid = 1'b0; in_hsync = 1'b0; in_de = 1'b0;
    tick;
    chk("lat2_valid", 32'(out_valid), 32'd0);
    tick;
    chk("def_valid", 32'(out_valid), 32'd1);
    chk("def_y", 32'(out_y), 32'd100);
    chk("def_u", 32'(out_u), 32'd200);
    chk("def_v", 32'(out_v), 32'd50);
    chk("def_hsync", 32'(out_hsync), 32'd1);
    chk("def_de", 32'(out_de), 32'd1);
    tick;
    chk("def_valid_drop", 32'(out_valid), 32'd0);

    // Contrast change mid-frame is held off until vsync.
    con = 14'sd8;
    tick;
    chk("mid_pending", 32'(param_pending), 32'd1);
    px(8'd100, 8'd128, 8'd128);
    chk("mid_y_old", 32'(out_y), 32'd100);
    vsync_pulse;
    chk("mid_pending_drop", 32'(param_pending), 32'd0);
    px(8'd100, 8'd128, 8'd128);
    chk("c8_y100", 32'(out_y), 32'd200);
    px(8'd200, 8'd128, 8'd128);
    chk("c8_y200_clamp", 32'(out_y), 32'd255);
    px(8'd0, 8'd128, 8'd128);
    chk("c8_y0", 32'(out_y), 32'd0);

    // Brightness and saturation.
    con = 14'sd4; bri = 14'sd4400; sat = 14'sd64;
    tick;
    vsync_pulse;
    px(8'd100, 8'd200, 8'd50);
    chk("bs_y", 32'(out_y), 32'd200);
    chk("bs_u", 32'(out_u), 32'd164);
    chk("bs_v", 32'(out_v), 32'd89);

    // Negative gains are computed signed and clamped.
    con = -14'sd4; bri = 14'sd4000; sat = -14'sd128;
    tick;
    vsync_pulse;
    px(8'd100, 8'd200, 8'd50);
    chk("neg_y", 32'(out_y), 32'd0);
    chk("neg_u", 32'(out_u), 32'd56);
    chk("neg_v", 32'(out_v), 32'd206);

    // Value present on the vsync edge is the one latched.
    con = 14'sd8; sat = 14'sd128;
    tick;
    con = 14'sd12; in_vsync = 1'b1;
    tick;
    in_vsync = 1'b0;
    tick;
    chk("edge_pending", 32'(param_pending), 32'd0);
    px(8'd50, 8'd200, 8'd128);
    chk("edge_y", 32'(out_y), 32'd150);
    chk("edge_u", 32'(out_u), 32'd200);

    // Returning to the shadow value while pending stays pending.
    con = 14'sd4;
    tick;
    con = 14'sd12;
    tick;
    chk("ret_pending", 32'(param_pending), 32'd1);
    vsync_pulse;
    chk("ret_pending_drop", 32'(param_pending), 32'd0);

`ifdef COLOR_ADJUST_STATS_EN
    con = 14'sd16;
    tick;
    vsync_pulse;
    for (int i = 0; i < 15; i++) begin
      in_valid = 1'b1;
      in_y = (i < 10) ? 8'd255 : 8'd10;
      in_u = 8'd128; in_v = 8'd128;
      tick;
    end
    in_valid = 1'b0;
    tick; tick; tick;
    vsync_pulse;
    chk("stats_clip", 32'(clip_count), 32'd10);
`endif

    // Reset with two pixels in flight.
    con = 14'sd4; bri = 14'sd4000; sat = 14'sd128;
    in_valid = 1'b1; in_y = 8'd100; in_u = 8'd200; in_v = 8'd50;
    tick;
    tick;
    in_valid = 1'b0;
    rst = 1'b1;
    tick;
    chk("rst2_valid", 32'(out_valid), 32'd0);
    chk("rst2_y", 32'(out_y), 32'd0);
    chk("rst2_pending", 32'(param_pending), 32'd0);
    rst = 1'b0;
    tick; tick; tick;
    chk("rst2_flushed", 32'(out_valid), 32'd0);
    px(8'd100, 8'd200, 8'd50);
    chk("rst2_def_y", 32'(out_y), 32'd100);
    chk("rst2_def_u", 32'(out_u), 32'd200);
    chk("rst2_def_v", 32'(out_v), 32'd50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
